// File: rtl/rssb_seq_if.sv
// rtl/rssb_seq_if.sv - data memory bus between the RSSB sequencer and its memory
interface rssb_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] mem_address;
  logic             mem_write;
  logic [WIDTH-1:0] mem_in;
  logic [WIDTH-1:0] mem_out;

  modport master (
    output mem_address,
    output mem_write,
    output mem_in,
    input  mem_out
  );

  modport slave (
    input  mem_address,
    input  mem_write,
    input  mem_in,
    output mem_out
  );
endinterface

// File: rtl/rssb_seq.sv
// rtl/rssb_seq.sv - RSSB instruction sequencer and datapath (optional single-step: RSSB_STEP_EN)
module rssb_seq #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  rssb_seq_if.master       bus,
`ifdef RSSB_STEP_EN
  input  logic             step,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             instr_done,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, acc_q, ir_q, mdr_q;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             fetch_go;

`ifdef RSSB_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // Extra top bit of the unsigned subtraction is the borrow flag.
  assign diff   = {1'b0, mdr_q} - {1'b0, acc_q};
  assign borrow = diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          state_d = (bus.mem_out == HALT_ADDR) ? S_HALT : S_READ;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      acc_q <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch_go) begin
            ir_q <= bus.mem_out;
          end
        end
        S_READ: mdr_q <= bus.mem_out;
        S_EXEC: begin
          acc_q <= diff[WIDTH-1:0];
          pc_q  <= pc_q + (borrow ? WIDTH'(2) : WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only, so reset drops mem_write at once.
  always_comb begin
    bus.mem_address = pc_q;
    bus.mem_write   = 1'b0;
    bus.mem_in      = '0;
    instr_done      = 1'b0;
    halted          = 1'b0;
    case (state_q)
      S_READ: bus.mem_address = ir_q;
      S_EXEC: begin
        bus.mem_address = ir_q;
        bus.mem_write   = 1'b1;
        bus.mem_in      = diff[WIDTH-1:0];
        instr_done      = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign pc  = pc_q;
  assign acc = acc_q;

endmodule
